// File: rtl/x_word_ser_pkg.sv
// x_ser_pkg: shared types and helpers for the word-to-byte serializer.
// Optional checksum byte is enabled by the X_WORD_SER_CSUM_EN macro.
package x_ser_pkg;

    localparam int BYTE_W = 8;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        SEND = 2'd1,
        CSUM = 2'd2
    } ser_state_t;

    // A requested length of zero, or one beyond the word size, means "whole word".
    function automatic int eff_len(input int len, input int nbytes);
        if (len == 0 || len > nbytes) begin
            return nbytes;
        end
        return len;
    endfunction

endpackage

// File: rtl/x_word_ser_if.sv
// x_word_ser_if: word-side and byte-side valid/accept handshakes of x_word_ser.
// slave is the serializer's view, master is the view of whoever drives it.
interface x_word_ser_if #(
    parameter int WIDTH = 32
);
    import x_ser_pkg::*;

    localparam int NBYTES = WIDTH / BYTE_W;
    localparam int LEN_W  = $clog2(NBYTES + 1);

    logic              i_valid;
    logic              o_accept;
    logic [WIDTH-1:0]  i_data;
    logic [LEN_W-1:0]  i_len;
    logic              o_valid;
    logic              i_accept;
    logic [BYTE_W-1:0] o_data;
    logic              o_busy;

    modport slave (
        input  i_valid, i_data, i_len, i_accept,
        output o_accept, o_valid, o_data, o_busy
    );

    modport master (
        output i_valid, i_data, i_len, i_accept,
        input  o_accept, o_valid, o_data, o_busy
    );

endinterface

// File: rtl/x_word_ser.sv
// x_word_ser: takes one parallel word and streams it out LSB byte first
// towards the UART transmitter. With X_WORD_SER_CSUM_EN defined, an XOR
// checksum byte follows the data bytes of every word.
module x_word_ser
    import x_ser_pkg::*;
#(
    parameter int WIDTH = 32
) (
    input  logic           i_clk,
    input  logic           i_rst,
    x_word_ser_if.slave    bus
);

    localparam int NBYTES = WIDTH / BYTE_W;
    localparam int LEN_W  = $clog2(NBYTES + 1);

    ser_state_t        state_reg, state_next;
    logic [WIDTH-1:0]  sreg_reg, sreg_next;
    logic [WIDTH-1:0]  sreg_shifted;
    logic [LEN_W-1:0]  cnt_reg, cnt_next;
`ifdef X_WORD_SER_CSUM_EN
    logic [BYTE_W-1:0] csum_reg, csum_next;
`endif

    // Byte lanes of the shift register move down one lane; the top lane fills with zero.
    generate
        for (genvar gi = 0; gi < NBYTES; gi++) begin : g_shift
            if (gi < NBYTES - 1) begin : g_mid
                assign sreg_shifted[gi*BYTE_W +: BYTE_W] = sreg_reg[(gi+1)*BYTE_W +: BYTE_W];
            end else begin : g_top
                assign sreg_shifted[gi*BYTE_W +: BYTE_W] = '0;
            end
        end
    endgenerate

    // Next-state and output decode; outputs depend on registered state only.
    always_comb begin
        state_next   = state_reg;
        sreg_next    = sreg_reg;
        cnt_next     = cnt_reg;
`ifdef X_WORD_SER_CSUM_EN
        csum_next    = csum_reg;
`endif
        bus.o_accept = 1'b0;
        bus.o_valid  = 1'b0;
        bus.o_data   = '0;
        bus.o_busy   = 1'b1;

        case (state_reg)
            IDLE: begin
                bus.o_accept = 1'b1;
                bus.o_busy   = 1'b0;
                if (bus.i_valid) begin
                    sreg_next  = bus.i_data;
                    cnt_next   = LEN_W'(eff_len(int'(bus.i_len), NBYTES));
`ifdef X_WORD_SER_CSUM_EN
                    csum_next  = '0;
`endif
                    state_next = SEND;
                end
            end

            SEND: begin
                bus.o_valid = 1'b1;
                bus.o_data  = sreg_reg[BYTE_W-1:0];
                if (bus.i_accept) begin
                    sreg_next = sreg_shifted;
                    cnt_next  = cnt_reg - LEN_W'(1);
`ifdef X_WORD_SER_CSUM_EN
                    csum_next = csum_reg ^ sreg_reg[BYTE_W-1:0];
`endif
                    if (cnt_reg == LEN_W'(1)) begin
`ifdef X_WORD_SER_CSUM_EN
                        state_next = CSUM;
`else
                        state_next = IDLE;
`endif
                    end
                end
            end

`ifdef X_WORD_SER_CSUM_EN
            CSUM: begin
                bus.o_valid = 1'b1;
                bus.o_data  = csum_reg;
                if (bus.i_accept) begin
                    state_next = IDLE;
                end
            end
`endif

            default: begin
                state_next = IDLE;
            end
        endcase
    end

    // State register; an active-low reset drops any word in flight.
    always_ff @(posedge i_clk) begin
        if (!i_rst) begin
            state_reg <= IDLE;
        end else begin
            state_reg <= state_next;
        end
    end

    // Datapath registers: shift register, remaining-byte counter, checksum.
    always_ff @(posedge i_clk) begin
        if (!i_rst) begin
            sreg_reg <= '0;
            cnt_reg  <= '0;
`ifdef X_WORD_SER_CSUM_EN
            csum_reg <= '0;
`endif
        end else begin
            sreg_reg <= sreg_next;
            cnt_reg  <= cnt_next;
`ifdef X_WORD_SER_CSUM_EN
            csum_reg <= csum_next;
`endif
        end
    end

endmodule

// File: tb/tb_x_word_ser.sv
// tb_x_word_ser: randomized and directed stimulus for x_word_ser, checked by a
// byte-stream scoreboard. Honours X_WORD_SER_CSUM_EN for the trailing checksum.
module tb_x_word_ser;
    import x_ser_pkg::*;

    localparam int WIDTH  = 32;
    localparam int NBYTES = WIDTH / 8;
    localparam int LEN_W  = $clog2(NBYTES + 1);
`ifdef X_WORD_SER_CSUM_EN
    localparam bit HAS_CSUM = 1'b1;
`else
    localparam bit HAS_CSUM = 1'b0;
`endif

    logic clk   = 1'b0;
    logic rst_n = 1'b0;

    always #5 clk = ~clk;

    x_word_ser_if #(.WIDTH(WIDTH)) bus ();

    x_word_ser #(.WIDTH(WIDTH)) dut (
        .i_clk (clk),
        .i_rst (rst_n),
        .bus   (bus)
    );

    int n_total = 0;
    int n_pass  = 0;

    // Scoreboard: bytes still owed by the DUT, oldest first.
    logic [7:0] exp_q[$];
    int  words      = 0;
    int  bytes_seen = 0;
    bit  started    = 1'b0;
    bit  after_rst  = 1'b0;
    int  acc_mode   = 0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_total++;
        if (act === exp) begin
            n_pass++;
        end else begin
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Reference: the word becomes its first n bytes (n after the length rule),
    // lowest byte first, optionally followed by their XOR.
    task automatic push_word(input logic [WIDTH-1:0] data, input int len);
        int n;
        logic [7:0] b;
        logic [7:0] x;
        n = (len == 0 || len > NBYTES) ? NBYTES : len;
        x = 8'h00;
        for (int k = 0; k < n; k++) begin
            b = 8'((data >> (8 * k)) & 32'hFF);
            exp_q.push_back(b);
            x = x ^ b;
        end
        if (HAS_CSUM) begin
            exp_q.push_back(x);
        end
        $display("word %0d: data=%08h len=%0d -> %0d byte(s)", words, data, len, n + int'(HAS_CSUM));
    endtask

    // Monitor: on every falling edge compare the DUT against the model, then
    // advance the model by whatever handshakes the coming rising edge will take.
    always @(negedge clk) begin
        bit pend;
        pend = (exp_q.size() != 0);
        if (started) begin
            check("o_valid", bus.o_valid, pend);
            check("o_accept", bus.o_accept, !pend);
            check("o_busy", bus.o_busy, pend);
            if (pend) begin
                check("o_data", bus.o_data, exp_q[0]);
            end
            if (after_rst) begin
                check("o_data_after_reset", bus.o_data, 8'h00);
            end
        end
        after_rst = 1'b0;
        if (!rst_n) begin
            if (pend) begin
                $display("reset: dropping %0d pending byte(s)", exp_q.size());
            end
            exp_q.delete();
            started   = 1'b1;
            after_rst = 1'b1;
        end else if (started) begin
            if (pend && bus.i_accept) begin
                void'(exp_q.pop_front());
                bytes_seen++;
            end
            if (!pend && bus.i_valid) begin
                push_word(bus.i_data, int'(bus.i_len));
                words++;
            end
        end
    end

    // Byte-side acceptor: 0 always, 1 every third cycle, 2 random.
    initial begin
        int ctr;
        ctr = 0;
        bus.i_accept = 1'b0;
        forever begin
            @(posedge clk);
            #1;
            ctr++;
            case (acc_mode)
                0:       bus.i_accept = 1'b1;
                1:       bus.i_accept = (ctr % 3 == 0);
                default: bus.i_accept = 1'($urandom_range(0, 1));
            endcase
        end
    end

    task automatic send_word(input logic [WIDTH-1:0] d, input int len);
        int w0;
        w0 = words;
        @(posedge clk);
        #1;
        bus.i_valid = 1'b1;
        bus.i_data  = d;
        bus.i_len   = LEN_W'(len);
        for (int t = 0; t < 300 && words == w0; t++) begin
            @(negedge clk);
        end
        check("capture_within_bound", (words != w0), 1'b1);
        @(posedge clk);
        #1;
        bus.i_valid = 1'b0;
        bus.i_data  = 32'($urandom);
        bus.i_len   = LEN_W'($urandom_range(0, 7));
    endtask

    task automatic wait_idle();
        for (int t = 0; t < 500 && exp_q.size() != 0; t++) begin
            @(negedge clk);
        end
        check("drain_within_bound", (exp_q.size() == 0), 1'b1);
        @(negedge clk);
    endtask

    initial begin
        int b0;
        bus.i_valid = 1'b0;
        bus.i_data  = '0;
        bus.i_len   = '0;
        rst_n       = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        rst_n = 1'b1;
        repeat (2) @(posedge clk);

        // Basic word, continuous accept.
        acc_mode = 0;
        send_word(32'hA1B2C3D4, 4);
        wait_idle();

        // Backpressure.
        acc_mode = 1;
        send_word(32'hA1B2C3D4, 4);
        wait_idle();

        // Length clamp.
        acc_mode = 0;
        send_word(32'hA1B2C3D4, 2);
        wait_idle();
        send_word(32'hA1B2C3D4, 0);
        wait_idle();
        send_word(32'hA1B2C3D4, 7);
        wait_idle();

        // Second word offered while busy, held until taken.
        send_word(32'hA1B2C3D4, 4);
        send_word(32'h11223344, 4);
        wait_idle();

        // Reset after two bytes accepted, then a fresh word.
        b0 = bytes_seen;
        send_word(32'hA1B2C3D4, 4);
        for (int t = 0; t < 100 && bytes_seen < b0 + 2; t++) begin
            @(negedge clk);
        end
        check("two_bytes_before_reset", (bytes_seen >= b0 + 2), 1'b1);
        @(posedge clk);
        #1;
        rst_n = 1'b0;
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        send_word(32'h00000055, 4);
        wait_idle();

        // Randomized words, lengths, gaps and acceptor behaviour.
        acc_mode = 2;
        for (int i = 0; i < 40; i++) begin
            repeat ($urandom_range(0, 3)) @(posedge clk);
            send_word(32'($urandom), int'($urandom_range(0, 7)));
        end
        wait_idle();

        repeat (5) @(posedge clk);
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation did not finish in time");
        $display("%0d/%0d checks passed", n_pass, n_total + 1);
        $fatal(1, "watchdog");
    end

endmodule
